// File: rtl/avr_uart_rx_fifo.sv
// avr_uart_rx_fifo: 8N1 receiver for the AVR serial link feeding a first-word-fall-through byte FIFO.
// Bytes are framed from a synchronized copy of rx and drained by the consumer with valid/ready.
module avr_uart_rx_fifo #(
    parameter int CLK_PER_BIT     = 100,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     rx,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     frame_err,
    output logic                     overflow
);
    localparam int DW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << DW;
    localparam int CW    = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLK_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLK_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, rs_q, rs_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            push, fall;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic [DW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW:0]     count_q, count_d;
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      mem_q [DEPTH];
    logic            pop, full, push_ok;

    assign fall = rs_prev_q && !rs_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        sh_d        = sh_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = (en && fall) ? CW'(1) : '0;
                bit_d   = 3'd0;
                state_d = (en && fall) ? START : IDLE;
            end
            START: if (cnt_q == HALF_BIT) begin
                cnt_d   = CW'(1);
                state_d = rs_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL_BIT) begin
                cnt_d   = CW'(1);
                sh_d    = {rs_q, sh_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            default: if (cnt_q == FULL_BIT) begin
                state_d     = IDLE;
                push        = rs_q;
                frame_err_d = !rs_q;
            end
        endcase
        // Losing the link abandons any partial frame silently.
        if (!en) begin
            state_d     = IDLE;
            push        = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_comb begin
        pop        = (count_q != '0) && out_ready;
        full       = count_q == (DW+1)'(DEPTH);
        push_ok    = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_d       = wr_q + DW'(push_ok);
        rd_d       = rd_q + DW'(pop);
        count_d    = count_q + (DW+1)'(push_ok) - (DW+1)'(pop);
        valid_d    = count_d != '0;
        // The new byte lands exactly at the next head when the FIFO is (about to be) empty.
        data_d     = (push_ok && wr_q == rd_d) ? sh_q : mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rs_q        <= 1'b1;
            rs_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx;
            rs_q        <= sync1_q;
            rs_prev_q   <= rs_q;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_q] <= sh_q;
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_avr_uart_rx_fifo.sv
// tb_avr_uart_rx_fifo: drives 8N1 frames at 8 clocks/bit and checks popped bytes against a queue of sent bytes.
module tb_avr_uart_rx_fifo;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, rx = 1'b1, out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, frame_err, overflow;
    logic [4:0] fifo_count;
    int         n_vec = 0, n_err = 0, ferr_n = 0, ovf_n = 0;
    logic [7:0] exp_q [$];

    avr_uart_rx_fifo #(.CLK_PER_BIT(8), .FIFO_DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .en(en), .rx(rx), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && frame_err) ferr_n++;
        if (!rst && overflow) ovf_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] e;
        e = exp_q.size() ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, out_data, e);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    // Stop sample lands 79 rising edges after the start bit is driven; pop_at_stop pulses ready there.
    task automatic send(input logic [7:0] b, input logic stop, input bit pop_at_stop);
        rx = 1'b0;
        idle(8);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(8);
        end
        rx = stop;
        if (pop_at_stop) begin
            idle(6);
            pop_one("pop_at_stop");
            idle(1);
        end else idle(8);
        rx = 1'b1;
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            idle(1);
            chk("rst_valid", out_valid, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_data", out_data, 0);
            chk("rst_flags", {frame_err, overflow}, 0);
        end
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        en = 1'b1;
        idle(4);

        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        chk("a5_count", fifo_count, 1);
        pop_one("a5_data");
        chk("a5_count_after_pop", fifo_count, 0);
        chk("a5_valid_after_pop", out_valid, 0);

        send(8'h3C, 1'b0, 1'b0);
        chk("ferr_pulses", ferr_n, 1);
        chk("ferr_count", fifo_count, 0);

        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(20);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_ferr", ferr_n, 1);

        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send(8'(i), 1'b1, 1'b0);
            chk("ovf_pulses", ovf_n, (i == 16) ? 1 : 0);
        end
        chk("full_count", fifo_count, 16);
        for (int i = 0; i < 16; i++) pop_one("drain");
        chk("drained_count", fifo_count, 0);
        chk("drained_valid", out_valid, 0);

        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(24);
        en = 1'b0;
        idle(2);
        idle(60);
        en = 1'b1;
        idle(4);
        chk("en_drop_count", fifo_count, 0);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0);
        chk("5a_count", fifo_count, 1);
        chk("5a_data", out_data, 8'h5A);
        for (int i = 1; i < 16; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            send(8'(8'h80 + i), 1'b1, 1'b0);
        end
        chk("refill_count", fifo_count, 16);
        exp_q.push_back(8'h99);
        send(8'h99, 1'b1, 1'b1);
        chk("push_pop_full_count", fifo_count, 16);
        chk("push_pop_full_ovf", ovf_n, 1);
        for (int i = 0; i < 16; i++) pop_one("drain2");
        chk("drain2_count", fifo_count, 0);

        exp_q.push_back(8'h42);
        send(8'h42, 1'b1, 1'b0);
        rx = 1'b0;
        idle(20);
        rst = 1'b1;
        rx = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_count", fifo_count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        idle(90);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_ferr", ferr_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
